// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the unified memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_D  = 1'b1
  } grant_t;

  // Both MEM_LAT and MAX_DSTREAK are limited to 1..15, so four bits hold either.
  localparam int unsigned LAT_CW   = 4;
  localparam int unsigned STREAK_W = 4;

endpackage

// File: rtl/arb_lat_counter.sv
// Memory latency down-counter: loads the latency, decrements while waiting,
// and flags the cycle in which it reads 1 (the response cycle).
module arb_lat_counter
  import mem_arb_pkg::*;
#(
  parameter int unsigned LOAD_VAL = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic dec_i,
  output logic tc_o
);

  logic [LAT_CW-1:0] cnt_q, cnt_d;

  // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LAT_CW'(LOAD_VAL);
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == LAT_CW'(1));

endmodule

// File: rtl/unified_mem_arbiter.sv
// Serialises fetch (IF) and data (D) accesses onto one single-ported synchronous
// memory. D wins ties unless it has already won MAX_DSTREAK times while IF waited.
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW          = 32,
  parameter int unsigned DW          = 32,
  parameter int unsigned MEM_LAT     = 2,
  parameter int unsigned MAX_DSTREAK = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  output logic          busy
);

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DSTREAK);

  state_t                state_q;
  grant_t                gnt_q, gnt_d;
  logic [STREAK_W-1:0]   streak_q, streak_d;
  logic                  m_en_q, m_we_q;
  logic [AW-1:0]         m_addr_q;
  logic [DW-1:0]         m_wdata_q;
  logic                  lat_tc;
  logic                  resp_cyc;

  always_comb begin
    gnt_d    = GNT_IF;
    streak_d = '0;
    if (d_req && !(if_req && (streak_q == STREAK_MAX))) begin
      gnt_d = GNT_D;
    end
    // The streak only grows while IF is actually being passed over.
    if ((gnt_d == GNT_D) && if_req) begin
      streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      gnt_q     <= GNT_IF;
      streak_q  <= '0;
      m_en_q    <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
    end else begin
      m_en_q <= 1'b0;
      m_we_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (if_req || d_req) begin
            state_q   <= ISSUE;
            gnt_q     <= gnt_d;
            streak_q  <= streak_d;
            m_en_q    <= 1'b1;
            m_we_q    <= (gnt_d == GNT_D) && d_we;
            m_addr_q  <= (gnt_d == GNT_D) ? d_addr : if_addr;
            m_wdata_q <= (gnt_d == GNT_D) ? d_wdata : '0;
          end
        end
        ISSUE: state_q <= WAIT;
        WAIT: begin
          if (lat_tc) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  arb_lat_counter #(
    .LOAD_VAL(MEM_LAT)
  ) u_lat (
    .clk_i (CLK),
    .rst_ni(RST),
    .load_i(state_q == ISSUE),
    .dec_i (state_q == WAIT),
    .tc_o  (lat_tc)
  );

  assign resp_cyc = (state_q == WAIT) && lat_tc;
  assign if_ack   = resp_cyc && (gnt_q == GNT_IF);
  assign d_ack    = resp_cyc && (gnt_q == GNT_D);
  assign if_rdata = if_ack ? m_rdata : '0;
  assign d_rdata  = d_ack ? m_rdata : '0;

  assign m_en    = m_en_q;
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign busy    = (state_q != IDLE);

  // The granted requester must hold its request and payload until its ack.
  a_if_hold: assert property (@(posedge CLK) disable iff (!RST)
    (state_q != IDLE && gnt_q == GNT_IF) |-> (if_req && $stable(if_addr)));
  a_d_hold: assert property (@(posedge CLK) disable iff (!RST)
    (state_q != IDLE && gnt_q == GNT_D) |->
      (d_req && $stable(d_we) && $stable(d_addr) && $stable(d_wdata)));
  a_one_ack: assert property (@(posedge CLK) disable iff (!RST) !(if_ack && d_ack));

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Randomised and directed bench for unified_mem_arbiter against a
// transaction-level model of grant order and access timing.
module tb_unified_mem_arbiter;

  localparam int L    = 2;
  localparam int MAXS = 4;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  logic        if_req = 0, d_req = 0, d_we = 0;
  logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0;
  logic [31:0] if_rdata, d_rdata, m_addr, m_wdata, m_rdata;
  logic        if_ack, d_ack, m_en, m_we, busy;

  unified_mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(L), .MAX_DSTREAK(MAXS)) u_dut (
    .CLK(CLK), .RST(RST),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .busy(busy)
  );

  // Second instance with single-cycle memory latency.
  logic        if_req1 = 0, d_req1 = 0, d_we1 = 0;
  logic [31:0] if_addr1 = 0, d_addr1 = 0, d_wdata1 = 0, m_rdata1 = 0;
  logic [31:0] if_rdata1, d_rdata1, m_addr1, m_wdata1;
  logic        if_ack1, d_ack1, m_en1, m_we1, busy1;

  unified_mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(1), .MAX_DSTREAK(MAXS)) u_dut1 (
    .CLK(CLK), .RST(RST),
    .if_req(if_req1), .if_addr(if_addr1), .if_rdata(if_rdata1), .if_ack(if_ack1),
    .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1),
    .d_rdata(d_rdata1), .d_ack(d_ack1),
    .m_en(m_en1), .m_we(m_we1), .m_addr(m_addr1), .m_wdata(m_wdata1), .m_rdata(m_rdata1),
    .busy(busy1)
  );

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  // Memory device: 256 words, read data appears L cycles after the strobe.
  logic [31:0] mem [256];
  logic [31:0] pipe_d [L];
  logic        pipe_v [L];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = init_word(32'(i) << 2);
    for (int i = 0; i < L; i++) begin
      pipe_v[i] = 1'b0;
      pipe_d[i] = '0;
    end
  end

  always @(posedge CLK) begin
    for (int i = L - 1; i > 0; i--) begin
      pipe_d[i] <= pipe_d[i-1];
      pipe_v[i] <= pipe_v[i-1];
    end
    pipe_v[0] <= m_en && !m_we;
    pipe_d[0] <= mem[m_addr[9:2]];
    if (m_en && m_we) mem[m_addr[9:2]] <= m_wdata;
  end
  assign m_rdata = pipe_v[L-1] ? pipe_d[L-1] : 32'hBAD0_BAD0;

  always @(posedge CLK) if (m_en1) m_rdata1 <= init_word(m_addr1);

  int n_checks = 0, n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Transaction-level reference: each access occupies [grant+1, grant+1+L].
  int          cyc = 0, next_arb = 0, iss_cyc = -100, ack_cyc = -100, streak_m = 0;
  bit          m_gnt_d;
  logic        exp_we;
  logic [31:0] exp_addr, exp_wdata, exp_rdata;
  logic [31:0] ref_mem [256];
  bit          ack_log [$];
  int          if_req_at, d_req_at, if_ack_at, d_ack_at;
  logic [31:0] if_rdata_seen;

  bit          frc_if = 0, frc_d = 0, frc_d_we = 0;
  logic [31:0] frc_if_addr, frc_d_addr, frc_d_wdata;

  function automatic logic [31:0] rand_addr();
    return 32'($urandom_range(255)) << 2;
  endfunction

  task automatic tick(input int p_if, input int p_d);
    bit e_men, e_ifa, e_da;
    @(posedge CLK);
    #1;
    cyc++;
    e_men = (cyc == iss_cyc);
    e_ifa = (cyc == ack_cyc) && !m_gnt_d;
    e_da  = (cyc == ack_cyc) && m_gnt_d;
    check("busy", busy, cyc < next_arb);
    check("m_en", m_en, e_men);
    if (e_men) begin
      check("m_we", m_we, exp_we);
      check("m_addr", m_addr, exp_addr);
      if (exp_we) check("m_wdata", m_wdata, exp_wdata);
    end
    check("if_ack", if_ack, e_ifa);
    check("d_ack", d_ack, e_da);
    if (e_ifa) check("if_rdata", if_rdata, exp_rdata);
    if (e_da && !exp_we) check("d_rdata", d_rdata, exp_rdata);
    if (if_ack) begin ack_log.push_back(1'b0); if_ack_at = cyc; if_rdata_seen = if_rdata; end
    if (d_ack) begin ack_log.push_back(1'b1); d_ack_at = cyc; end

    // Requesters: drop the cycle after their ack, then maybe ask again.
    if (cyc == ack_cyc + 1) begin
      if (m_gnt_d) d_req = 1'b0;
      else if_req = 1'b0;
    end
    if (!if_req && (frc_if || $urandom_range(999) < p_if)) begin
      if_req    = 1'b1;
      if_addr   = frc_if ? frc_if_addr : rand_addr();
      if_req_at = cyc;
      frc_if    = 0;
    end
    if (!d_req && (frc_d || $urandom_range(999) < p_d)) begin
      d_req    = 1'b1;
      d_we     = frc_d ? frc_d_we : 1'($urandom_range(1));
      d_addr   = frc_d ? frc_d_addr : rand_addr();
      d_wdata  = frc_d ? frc_d_wdata : $urandom;
      d_req_at = cyc;
      frc_d    = 0;
    end

    if (cyc >= next_arb && (if_req || d_req)) begin
      m_gnt_d = d_req && !(if_req && streak_m == MAXS);
      if (m_gnt_d && if_req) streak_m = (streak_m < MAXS) ? streak_m + 1 : MAXS;
      else streak_m = 0;
      exp_we    = m_gnt_d ? d_we : 1'b0;
      exp_addr  = m_gnt_d ? d_addr : if_addr;
      exp_wdata = d_wdata;
      exp_rdata = ref_mem[exp_addr[9:2]];
      if (exp_we) ref_mem[exp_addr[9:2]] = d_wdata;
      iss_cyc  = cyc + 1;
      ack_cyc  = cyc + 1 + L;
      next_arb = cyc + 2 + L;
    end
  endtask

  task automatic do_reset();
    RST = 1'b0;
    #1;
    check("rst_outs", {m_en, m_we, |m_addr, |m_wdata, if_ack, d_ack, busy, |if_rdata, |d_rdata}, '0);
    if_req = 0; d_req = 0; frc_if = 0; frc_d = 0;
    iss_cyc = -100; ack_cyc = -100; next_arb = 0; streak_m = 0;
    ack_log.delete();
    repeat (2) @(posedge CLK);
    #2;
    RST = 1'b1;
  endtask

  bit exp_seq [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    int k, nacks, last_k, first_k;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(32'(i) << 2);
    do_reset();

    // Single IF read.
    frc_if = 1; frc_if_addr = 32'h40;
    repeat (6) tick(0, 0);
    check("t1_ack_lat", 64'(if_ack_at - if_req_at), 64'd3);

    // D write, then fetch it back.
    frc_d = 1; frc_d_we = 1; frc_d_addr = 32'h80; frc_d_wdata = 32'hDEAD_BEEF;
    repeat (6) tick(0, 0);
    check("t2_ack_lat", 64'(d_ack_at - d_req_at), 64'd3);
    check("t2_mem", mem[32], 32'hDEAD_BEEF);
    frc_if = 1; frc_if_addr = 32'h80;
    repeat (6) tick(0, 0);
    check("t2_readback", if_rdata_seen, 32'hDEAD_BEEF);

    // Simultaneous requests: D first.
    frc_if = 1; frc_if_addr = 32'h44;
    frc_d = 1; frc_d_we = 0; frc_d_addr = 32'h48; frc_d_wdata = 32'h0;
    repeat (10) tick(0, 0);
    check("t3_d_lat", 64'(d_ack_at - d_req_at), 64'd3);
    check("t3_if_lat", 64'(if_ack_at - if_req_at), 64'd7);

    // Starvation limit: D hammers while IF waits.
    do_reset();
    frc_if = 1; frc_if_addr = 32'h10;
    repeat (30) tick(0, 1000);
    check("t4_count", ack_log.size() >= 6, 1);
    for (int i = 0; i < 6 && i < ack_log.size(); i++)
      check($sformatf("t4_grant%0d", i), ack_log[i], exp_seq[i]);
    repeat (8) tick(0, 0);

    // Reset during WAIT of a read.
    do_reset();
    frc_if = 1; frc_if_addr = 32'h100;
    repeat (3) tick(0, 0);
    do_reset();
    repeat (6) tick(0, 0);
    check("t5_no_ack", ack_log.size(), 0);
    frc_if = 1; frc_if_addr = 32'h104;
    repeat (6) tick(0, 0);
    check("t5_after", 64'(if_ack_at - if_req_at), 64'd3);

    // Random traffic with one reset midway.
    repeat (1500) tick(300, 400);
    repeat (2) tick(0, 0);
    do_reset();
    repeat (1500) tick(400, 300);
    repeat (10) tick(0, 0);

    // MEM_LAT=1: back-to-back fetches every 3 cycles.
    nacks = 0; last_k = 0; first_k = -1; k = 0;
    @(posedge CLK); #1;
    if_req1 = 1'b1; if_addr1 = 32'h200;
    for (int j = 0; j < 21; j++) begin
      bit chg;
      chg = (nacks > 0) && (k == last_k);
      @(posedge CLK); #1;
      k++;
      if (chg) if_addr1 = if_addr1 + 32'd4;
      if (if_ack1) begin
        check("t6_rdata", if_rdata1, init_word(if_addr1));
        if (nacks > 0) check("t6_gap", 64'(k - last_k), 64'd3);
        else first_k = k;
        last_k = k;
        nacks++;
      end
    end
    if_req1 = 1'b0;
    check("t6_first", 64'(first_k), 64'd2);
    check("t6_count", nacks, 7);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
